calc1_port_sequencer: RTL
=========================

// Module: calc1_port_sequencer
// PURPOSE
//  Upstream stimulus stage for one calc1 request port. Queues transactions {cmd,op1,op2} and
//  drives the calc1 two-cycle request protocol (cmd+op1, then NOP+op2). Holds one outstanding
//  request until the response arrives, then reports code/data. Four instances feed ports 1..4.
// PARAMETERS
//  DEPTH           4   transaction queue entries (power of 2, >=2)
//  TIMEOUT_CYCLES  64  WAIT-state cycles before timeout (used only with CALC1_SEQ_TIMEOUT_EN)
// PORTS
//  c_clk          in   1   clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  txn_valid      in   1   transaction offered
//  txn_ready      out  1   queue can accept (= !full)
//  txn_cmd        in   4   calc1 command (0 NOP,1 ADD,2 SUB,5 LSH,6 RSH; others passed as-is)
//  txn_op1        in   32  operand 1
//  txn_op2        in   32  operand 2
//  req_cmd_out    out  4   to calc1 req_cmdN_in
//  req_data_out   out  32  to calc1 req_dataN_in
//  out_resp       in   2   from calc1 out_respN (0 none,1 ok,2 overflow/invalid,3 internal err)
//  out_data       in   32  from calc1 out_dataN
//  rsp_valid      out  1   one-cycle pulse: result available
//  rsp_code       out  2   captured out_resp; held until next rsp_valid
//  rsp_data       out  32  captured out_data; held until next rsp_valid
//  rsp_timeout    out  1   qualifies rsp_valid as timeout; constant 0 without macro
//  spurious_resp  out  1   one-cycle pulse: out_resp!=0 outside WAIT
//  busy           out  1   state != IDLE or queue non-empty
// BEHAVIOUR
//  Reset: state IDLE, queue flushed, all outputs 0 (txn_ready=1 next cycle). Applies mid-transaction.
//  Queue: FIFO order; push on valid&&ready; txn_ready=!full even if popping that edge.
//  FSM (outputs registered):
//   IDLE : queue non-empty -> pop into current reg, -> SEND1.
//   SEND1: req_cmd_out=cmd, req_data_out=op1 for exactly one cycle; -> SEND2.
//   SEND2: req_cmd_out=0, req_data_out=op2 for one cycle; -> WAIT.
//   WAIT : req_cmd_out=0, req_data_out=0; on edge sampling out_resp!=0: capture code/data,
//          rsp_valid=1 next cycle, -> IDLE.
//  Latency: push at edge E0 into empty queue -> cmd on bus in cycle after E1, op2 after E2.
//  Back-to-back: IDLE may pop on the edge after the response edge; min 4 cycles/transaction.
//  out_resp!=0 in IDLE/SEND1/SEND2: ignored for results, spurious_resp pulse next cycle.
//  Command codes not filtered; invalid codes rely on calc1 returning 2.
// CONFIGURATION
//  CALC1_SEQ_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle;
//   after TIMEOUT_CYCLES cycles with no response: rsp_valid=1, rsp_timeout=1, rsp_code=0,
//   rsp_data=0, -> IDLE. Response on the expiry cycle wins (normal result, rsp_timeout=0).
//   Late response after timeout -> spurious_resp.
//  Undefined: no counter; WAIT persists until response or reset; rsp_timeout tied 0.
// STRUCTURE
//  Shared header calc1_defs.vh: CMD_NOP/ADD/SUB/LSH/RSH, RSP_NONE/SUCC/INOF/IERR,
//   FSM state encodings (IDLE,SEND1,SEND2,WAIT); shared with driver and reference model.
//  Sub-module calc1_seq_fifo (DEPTH x 68b {cmd,op1,op2}, push/pop/full/empty, sync reset).
//  FSM, current-txn register, response capture, timeout counter stay in top.
// TESTING
//  1 Reset, push {ADD,255,1}; model replies 1/256 -> bus 1/255 then 0/1; rsp_valid, code 1, data 256.
//  2 Push {SUB,0,1}; model replies 2 -> rsp_code=2, rsp_data as returned, rsp_timeout=0.
//  3 Stall response, push 6 txns -> 1 in flight + 4 queued, txn_ready=0 on 6th; release -> FIFO order.
//  4 Reset asserted in WAIT -> outputs 0, queue empty; later out_resp=1 -> spurious_resp, no rsp_valid.
//  5 Macro on, no response for 64 WAIT cycles -> rsp_valid, rsp_timeout=1, code 0; macro off -> busy held.
//  6 out_resp=1 while IDLE with empty queue -> spurious_resp one cycle, rsp_code/rsp_data unchanged.

Source files
------------

// File: rtl/calc1_port_sequencer_pkg.sv
// Shared definitions for the calc1 port sequencer: command and response
// codes, FSM state encoding and the queued transaction record.
package calc1_port_sequencer_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_LSH = 4'd5;
    localparam logic [3:0] CMD_RSH = 4'd6;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_SUCC = 2'd1;
    localparam logic [1:0] RSP_INOF = 2'd2;
    localparam logic [1:0] RSP_IERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND1 = 2'd1,
        ST_SEND2 = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // One queued request: 68 bits {cmd, op1, op2}
    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } txn_t;

endpackage

// File: rtl/calc1_seq_fifo.sv
// Transaction queue for the calc1 port sequencer: DEPTH entries of txn_t,
// first-word-fall-through read, synchronous active-high reset.
module calc1_seq_fifo
    import calc1_port_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic c_clk,
    input  logic reset,
    input  logic push,
    input  txn_t wr_txn,
    input  logic pop,
    output txn_t rd_txn,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    txn_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra wrap bit distinguishes full from empty when the indices match
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_txn = mem[rd_ptr[AW-1:0]];

    // Pointer update; a reset flushes the queue without touching storage
    always_ff @(posedge c_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write, no reset needed for the data array
    always_ff @(posedge c_clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_txn;
        end
    end

endmodule

// File: rtl/calc1_port_sequencer.sv
// Upstream stimulus stage for one calc1 request port: queues transactions,
// drives the two-cycle request (cmd+op1, then NOP+op2), holds one request
// outstanding until out_resp arrives and reports the captured result.
// Optional build macro CALC1_SEQ_TIMEOUT_EN adds a WAIT-state timeout.
//
// state | meaning
// IDLE  | no request outstanding; pops the queue head when available
// SEND1 | cmd and op1 on the request bus
// SEND2 | NOP and op2 on the request bus
// WAIT  | bus idle, waiting for a non-zero out_resp (or timeout)
module calc1_port_sequencer
    import calc1_port_sequencer_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        txn_valid,
    output logic        txn_ready,
    input  logic [3:0]  txn_cmd,
    input  logic [31:0] txn_op1,
    input  logic [31:0] txn_op2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_code,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        spurious_resp,
    output logic        busy
);

    state_t      state;
    logic [31:0] cur_op2;
    txn_t        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        resp_seen;

    assign txn_ready = !fifo_full;
    assign resp_seen = (out_resp != RSP_NONE);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    calc1_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .c_clk  (c_clk),
        .reset  (reset),
        .push   (txn_valid && !fifo_full),
        .wr_txn ('{cmd: txn_cmd, op1: txn_op1, op2: txn_op2}),
        .pop    ((state == ST_IDLE) && !fifo_empty),
        .rd_txn (fifo_rd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef CALC1_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    assign rsp_timeout = timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign rsp_timeout    = 1'b0;
`endif

    // Request sequencing FSM with registered bus and response outputs
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cur_op2       <= '0;
            req_cmd_out   <= '0;
            req_data_out  <= '0;
            rsp_valid     <= 1'b0;
            rsp_code      <= '0;
            rsp_data      <= '0;
            spurious_resp <= 1'b0;
`ifdef CALC1_SEQ_TIMEOUT_EN
            wait_cnt      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            rsp_valid     <= 1'b0;
            spurious_resp <= 1'b0;
            case (state)
                ST_IDLE: begin
                    spurious_resp <= resp_seen;
                    if (!fifo_empty) begin
                        cur_op2      <= fifo_rd.op2;
                        req_cmd_out  <= fifo_rd.cmd;
                        req_data_out <= fifo_rd.op1;
                        state        <= ST_SEND1;
                    end
                end
                ST_SEND1: begin
                    spurious_resp <= resp_seen;
                    req_cmd_out   <= CMD_NOP;
                    req_data_out  <= cur_op2;
                    state         <= ST_SEND2;
                end
                ST_SEND2: begin
                    spurious_resp <= resp_seen;
                    req_cmd_out   <= CMD_NOP;
                    req_data_out  <= '0;
                    state         <= ST_WAIT;
`ifdef CALC1_SEQ_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                end
                ST_WAIT: begin
                    // A response on the expiry cycle still counts as a normal result
                    if (resp_seen) begin
                        rsp_valid <= 1'b1;
                        rsp_code  <= out_resp;
                        rsp_data  <= out_data;
                        state     <= ST_IDLE;
`ifdef CALC1_SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_code  <= RSP_NONE;
                        rsp_data  <= '0;
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_ONE;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
